// File: rtl/matrix_c_unloader_if.sv
// Bundles the C-RAM read port and the element output stream of the matrix C unloader.
// master = unloader side, slave = RAM/consumer side.
interface matrix_c_unloader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int ELEM_WIDTH = 8,
    parameter int MAT_DIM    = 4,
    parameter int IDX_WIDTH  = 2
);
    logic                          ram_en;
    logic [ADDR_WIDTH-1:0]         ram_addr;
    logic [MAT_DIM*ELEM_WIDTH-1:0] ram_rdata;
    logic                          out_valid;
    logic                          out_ready;
    logic [ELEM_WIDTH-1:0]         out_data;
    logic [IDX_WIDTH-1:0]          out_row;
    logic [IDX_WIDTH-1:0]          out_col;
    logic                          out_last;

    modport master (
        output ram_en,
        output ram_addr,
        input  ram_rdata,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_row,
        output out_col,
        output out_last
    );

    modport slave (
        input  ram_en,
        input  ram_addr,
        output ram_rdata,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_row,
        input  out_col,
        input  out_last
    );
endinterface

// File: rtl/matrix_c_unloader.sv
// Reads the MAT_DIM x MAT_DIM result matrix C (one column per RAM word, row r in byte r),
// buffers it, then streams the elements row-major on a valid/ready interface.
module matrix_c_unloader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int STRIDE_WIDTH = 8,
    parameter int ELEM_WIDTH   = 8,
    parameter int MAT_DIM      = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [STRIDE_WIDTH-1:0] addr_stride,
    output logic                    busy,
    output logic                    done,
    matrix_c_unloader_if.master     bus
);
    localparam int                 IDX_W    = (MAT_DIM > 1) ? $clog2(MAT_DIM) : 1;
    localparam int                 WORD_W   = MAT_DIM * ELEM_WIDTH;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MAT_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [STRIDE_WIDTH-1:0] r_stride;
    logic [IDX_W-1:0]        r_k;
    logic [IDX_W-1:0]        r_row;
    logic [IDX_W-1:0]        r_col;
    logic                    r_cap_en;
    logic [IDX_W-1:0]        r_cap_idx;
    logic [WORD_W-1:0]       w_words [MAT_DIM];
    logic [WORD_W-1:0]       w_col_word;
    logic                    w_hs;
    logic                    w_at_last;

    assign w_hs      = (r_state == S_STREAM) && bus.out_ready;
    assign w_at_last = (r_row == LAST_IDX) && (r_col == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_READ;
            S_READ:   if (r_k == LAST_IDX) w_state_next = S_WAIT;
            S_WAIT:   w_state_next = S_STREAM;
            S_STREAM: if (w_hs && w_at_last) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Address is accumulated rather than multiplied; wrap at 2^ADDR_WIDTH is intentional.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= '0;
            r_stride  <= '0;
            r_k       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_cap_en  <= 1'b0;
            r_cap_idx <= '0;
        end else begin
            r_cap_en  <= (r_state == S_READ);
            r_cap_idx <= r_k;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr   <= base_addr;
                        r_stride <= addr_stride;
                        r_k      <= '0;
                        r_row    <= '0;
                        r_col    <= '0;
                    end
                end
                S_READ: begin
                    r_addr <= r_addr + ADDR_WIDTH'(r_stride);
                    r_k    <= r_k + IDX_W'(1);
                end
                S_STREAM: begin
                    if (w_hs) begin
                        if (r_col == LAST_IDX) begin
                            r_col <= '0;
                            r_row <= r_row + IDX_W'(1);
                        end else begin
                            r_col <= r_col + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // One column word per buffer slot, written one cycle after its address was issued.
    generate
        for (genvar gi = 0; gi < MAT_DIM; gi++) begin : g_buf
            logic [WORD_W-1:0] r_word;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_word <= '0;
                end else if (r_cap_en && (r_cap_idx == IDX_W'(gi))) begin
                    r_word <= bus.ram_rdata;
                end
            end

            assign w_words[gi] = r_word;
        end
    endgenerate

    assign w_col_word = w_words[r_col];

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_addr  = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_row   = '0;
        bus.out_col   = '0;
        bus.out_last  = 1'b0;
        busy          = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        if (r_state == S_READ) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = r_addr;
        end
        if (r_state == S_STREAM) begin
            bus.out_valid = 1'b1;
            bus.out_data  = w_col_word[int'(r_row)*ELEM_WIDTH +: ELEM_WIDTH];
            bus.out_row   = r_row;
            bus.out_col   = r_col;
            bus.out_last  = w_at_last;
        end
    end
endmodule

// File: tb/tb_matrix_c_unloader.sv
// Directed bench for matrix_c_unloader: RAM model with 1-cycle read latency and a
// stream collector; each test task checks its own results against hand-derived values.
module tb_matrix_c_unloader;
    localparam int AW = 10;
    localparam int SW = 8;
    localparam int EW = 8;
    localparam int MD = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [SW-1:0] addr_stride = '0;
    logic          busy;
    logic          done;

    matrix_c_unloader_if #(.ADDR_WIDTH(AW), .ELEM_WIDTH(EW), .MAT_DIM(MD), .IDX_WIDTH(2)) bus ();

    matrix_c_unloader #(
        .ADDR_WIDTH(AW), .STRIDE_WIDTH(SW), .ELEM_WIDTH(EW), .MAT_DIM(MD)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .base_addr(base_addr),
        .addr_stride(addr_stride),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [1024];
    always @(posedge clk) if (bus.ram_en) bus.ram_rdata <= ram[bus.ram_addr];

    logic [31:0] basic_words [4] = '{32'h363E4B62, 32'h28303F5A, 32'h2E2C3352, 32'h0D131A22};
    logic [7:0]  exp_basic [16] = '{8'h62, 8'h5A, 8'h52, 8'h22, 8'h4B, 8'h3F, 8'h33, 8'h1A,
                                    8'h3E, 8'h30, 8'h2C, 8'h13, 8'h36, 8'h28, 8'h2E, 8'h0D};

    logic [7:0]    got_data [16];
    logic [1:0]    got_row  [16];
    logic [1:0]    got_col  [16];
    logic          got_last [16];
    logic [AW-1:0] got_addr [8];
    int            n_el, n_en, n_done, done_cyc, stab_err;
    bit            timed_out;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic load_words(input logic [AW-1:0] b, input logic [SW-1:0] s, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0]   w [4];
        logic [AW-1:0] a;
        w = '{w0, w1, w2, w3};
        a = b;
        for (int k = 0; k < 4; k++) begin
            ram[a] = w[k];
            a = a + AW'(s);
        end
    endtask

    // mode 0: ready held high; 1: random backpressure; 2: ready high plus stray start pulses.
    task automatic run_unload(input logic [AW-1:0] b, input logic [SW-1:0] s, input int mode, input int abort_at);
        logic [7:0] hd;
        logic [1:0] hr, hc;
        logic       hl;
        bit         stalled;
        int         cyc;
        n_el = 0; n_en = 0; n_done = 0; done_cyc = -1; stab_err = 0; timed_out = 0; stalled = 0;
        base_addr = b; addr_stride = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = '0; addr_stride = '0;
        cyc = 0;
        forever begin
            if (abort_at >= 0 && n_el == abort_at) begin
                resetn = 1'b0;
                #1;
                return;
            end
            bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.ram_en) begin
                if (n_en < 8) got_addr[n_en] = bus.ram_addr;
                n_en++;
            end
            if (stalled && (!bus.out_valid || bus.out_data !== hd || bus.out_row !== hr ||
                            bus.out_col !== hc || bus.out_last !== hl)) stab_err++;
            stalled = 0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (n_el < 16) begin
                        got_data[n_el] = bus.out_data; got_row[n_el] = bus.out_row;
                        got_col[n_el]  = bus.out_col;  got_last[n_el] = bus.out_last;
                    end
                    n_el++;
                end else begin
                    stalled = 1;
                    hd = bus.out_data; hr = bus.out_row; hc = bus.out_col; hl = bus.out_last;
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            start = (mode == 2 && (n_el == 8 || done)) ? 1'b1 : 1'b0;
            if (done_cyc >= 0 && cyc >= done_cyc + 6) break;
            if (cyc > 400) begin
                timed_out = 1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        bus.out_ready = 1'b0;
        $display("unload base=%h stride=%0d mode=%0d elems=%0d ram_en_cycles=%0d done_cycle=%0d",
                 b, s, mode, n_el, n_en, done_cyc);
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.ram_en !== 1'b0) begin n_err++; $display("FAIL reset_ram_en got=%b exp=0", bus.ram_en); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        load_words(10'h000, 8'd1, basic_words[0], basic_words[1], basic_words[2], basic_words[3]);
        run_unload(10'h000, 8'd1, 0, -1);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL basic_timeout got=timeout exp=done"); end
        n_cmp++; if (n_el !== 16) begin n_err++; $display("FAIL basic_count got=%0d exp=16", n_el); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (got_data[i] !== exp_basic[i]) begin n_err++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got_data[i], exp_basic[i]); end
            n_cmp++; if (got_row[i] !== 2'(i / 4) || got_col[i] !== 2'(i % 4)) begin n_err++; $display("FAIL basic_rc[%0d] got=%0d,%0d exp=%0d,%0d", i, got_row[i], got_col[i], i / 4, i % 4); end
            n_cmp++; if (got_last[i] !== (i == 15)) begin n_err++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, got_last[i], i == 15); end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got_addr[k] !== AW'(k)) begin n_err++; $display("FAIL basic_addr[%0d] got=%h exp=%h", k, got_addr[k], k); end
        end
        n_cmp++; if (n_en !== 4) begin n_err++; $display("FAIL basic_en_cycles got=%0d exp=4", n_en); end
        // done is active in the 22nd cycle counting the start-sampling cycle as the first.
        n_cmp++; if (done_cyc !== 21) begin n_err++; $display("FAIL basic_done_latency got=%0d exp=21", done_cyc); end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL basic_done_pulses got=%0d exp=1", n_done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stride_wrap();
        logic [AW-1:0] exp_addr [4] = '{10'h3FE, 10'h001, 10'h004, 10'h007};
        load_words(10'h3FE, 8'd3, basic_words[0], basic_words[1], basic_words[2], basic_words[3]);
        run_unload(10'h3FE, 8'd3, 0, -1);
        n_cmp++; if (n_en !== 4) begin n_err++; $display("FAIL wrap_en_cycles got=%0d exp=4", n_en); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got_addr[k] !== exp_addr[k]) begin n_err++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", k, got_addr[k], exp_addr[k]); end
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (got_data[i] !== exp_basic[i]) begin n_err++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, got_data[i], exp_basic[i]); end
        end
    endtask

    task automatic test_backpressure();
        load_words(10'h000, 8'd1, basic_words[0], basic_words[1], basic_words[2], basic_words[3]);
        run_unload(10'h000, 8'd1, 1, -1);
        n_cmp++; if (timed_out) begin n_err++; $display("FAIL bp_timeout got=timeout exp=done"); end
        n_cmp++; if (n_el !== 16) begin n_err++; $display("FAIL bp_count got=%0d exp=16", n_el); end
        n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL bp_stall_stability got=%0d exp=0", stab_err); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (got_data[i] !== exp_basic[i]) begin n_err++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_data[i], exp_basic[i]); end
        end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL bp_done_pulses got=%0d exp=1", n_done); end
    endtask

    task automatic test_start_ignored();
        load_words(10'h000, 8'd1, basic_words[0], basic_words[1], basic_words[2], basic_words[3]);
        run_unload(10'h000, 8'd1, 2, -1);
        n_cmp++; if (n_en !== 4) begin n_err++; $display("FAIL ign_en_cycles got=%0d exp=4", n_en); end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL ign_done_pulses got=%0d exp=1", n_done); end
        n_cmp++; if (n_el !== 16) begin n_err++; $display("FAIL ign_count got=%0d exp=16", n_el); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_stream();
        load_words(10'h000, 8'd1, basic_words[0], basic_words[1], basic_words[2], basic_words[3]);
        run_unload(10'h000, 8'd1, 0, 5);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
        n_cmp++; if (bus.ram_en !== 1'b0) begin n_err++; $display("FAIL midrst_ram_en got=%b exp=0", bus.ram_en); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (got_data[i] !== exp_basic[i]) begin n_err++; $display("FAIL midrst_pre[%0d] got=%h exp=%h", i, got_data[i], exp_basic[i]); end
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_unload(10'h000, 8'd1, 0, -1);
        n_cmp++; if (n_el !== 16) begin n_err++; $display("FAIL midrst_rerun_count got=%0d exp=16", n_el); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (got_data[i] !== exp_basic[i]) begin n_err++; $display("FAIL midrst_rerun[%0d] got=%h exp=%h", i, got_data[i], exp_basic[i]); end
        end
        n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL midrst_done_pulses got=%0d exp=1", n_done); end
    endtask

    task automatic test_matmul_integration();
        int          ma [4][4] = '{'{1, 2, 3, 4}, '{-1, 0, 2, 5}, '{3, -2, 1, 0}, '{2, 2, -3, 1}};
        int          mb [4][4] = '{'{1, 0, 2, -1}, '{0, 1, 3, 2}, '{4, -1, 0, 1}, '{2, 3, -2, 1}};
        logic [7:0]  mc [4][4];
        logic [31:0] w [4];
        int          acc;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) acc += ma[i][k] * mb[k][j];
                mc[i][j] = acc[7:0];
            end
        end
        for (int j = 0; j < 4; j++) begin
            w[j] = '0;
            for (int i = 0; i < 4; i++) w[j][i*8 +: 8] = mc[i][j];
        end
        load_words(10'h100, 8'd2, w[0], w[1], w[2], w[3]);
        run_unload(10'h100, 8'd2, 0, -1);
        n_cmp++; if (n_el !== 16) begin n_err++; $display("FAIL mm_count got=%0d exp=16", n_el); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (got_data[i] !== mc[i / 4][i % 4]) begin n_err++; $display("FAIL mm_data[%0d] got=%h exp=%h", i, got_data[i], mc[i / 4][i % 4]); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stride_wrap();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_stream();
        test_matmul_integration();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/matrix_c_unloader.md
Name: matrix_c_unloader

Overview:
Reader at the far end of the matmul result path. After the matmul asserts done, this block reads the 4x4 int8/fp8 result matrix C out of the C RAM. It uses the same base-address/stride convention as the matmul: one column per RAM word, row r in byte r. It buffers the whole matrix, then streams the 16 elements out in row-major order on a valid/ready interface to the host-side consumer.

Parameters:
ADDR_WIDTH, 10, RAM address width
STRIDE_WIDTH, 8, address stride width
ELEM_WIDTH, 8, bits per matrix element
MAT_DIM, 4, matrix dimension; RAM word = MAT_DIM*ELEM_WIDTH bits

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset (clock and reset named as in the codebase; asynchronous, active-low)
start  input  1  request unload; sampled only in IDLE
base_addr  input  ADDR_WIDTH  address of column 0 of C (same meaning as address_mat_c)
addr_stride  input  STRIDE_WIDTH  address increment between columns (same meaning as address_stride_c)
ram_en  output  1  RAM read enable
ram_addr  output  ADDR_WIDTH  RAM read address
ram_rdata  input  MAT_DIM*ELEM_WIDTH  RAM read data; valid the cycle after ram_en is sampled (1-cycle latency)
out_valid  output  1  element available
out_ready  input  1  consumer accepts element
out_data  output  ELEM_WIDTH  element C[row][col]
out_row  output  2  row index of out_data
out_col  output  2  column index of out_data
out_last  output  1  high with element (3,3)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last element handshake

Behaviour:
- Reset (async assert, sync deassert use): state goes to IDLE. All outputs 0. Column counter and element counters go to 0. The buffer content is don't-care.
- States: IDLE, READ, WAIT, STREAM, DONE.
- IDLE:
  - On start=1 at a rising edge, latch base_addr and addr_stride, set col_cnt=0, and go to READ.
  - start is ignored in every other state.
- READ, 4 cycles, k=0..3:
  - ram_en=1 and ram_addr = base + k*stride, modulo 2^ADDR_WIDTH (wrap-around is silent).
  - After k=3, go to WAIT.
- Capture:
  - ram_rdata is captured into buf[k] one cycle after the cycle in which address k was driven.
  - A delayed enable/index pipeline register controls this capture.
- WAIT, 1 cycle: ram_en=0; buf[3] is captured; go to STREAM.
- STREAM:
  - out_valid=1; out_data = buf[col][row*ELEM_WIDTH +: ELEM_WIDTH].
  - Order: row-major (row 0 cols 0..3, then row 1, ...).
  - Advance only on out_valid && out_ready.
  - out_data, out_row, out_col and out_last stay stable while out_ready=0.
  - Handshake on (3,3) goes to DONE.
- DONE, 1 cycle: done=1, out_valid=0, then IDLE. If start=1 in this cycle it is ignored.
- Latency: start sampled at edge E0; ram_en high in cycles E0-E4; first out_valid in the cycle after E5. With out_ready held at 1: 16 stream cycles, then done one cycle later.
- Elements are passed through unaltered: no sign extension and no fp8 interpretation.
- out_valid never drops before its handshake except on reset.
- Reset mid-operation (any state): immediate return to IDLE. No done pulse. Partial data is discarded. No ram_en after reset.

Test Plan:
- Basic unload:
  - Stimulus: RAM at base 0, stride 1, holds words 0x363E4B62, 0x28303F5A, 0x2E2C3352, 0x0D131A22. Pulse start; out_ready=1.
  - Response: stream 62 5A 52 22 4B 3F 33 1A 3E 30 2C 13 36 28 2E 0D (hex). out_last only on 0D at row 3, col 3. done exactly 1 cycle, 22 cycles after start is sampled.
- Stride/wrap:
  - Stimulus: base=0x3FE, stride=3.
  - Response: ram_addr sequence 0x3FE, 0x001, 0x004, 0x007. ram_en high exactly 4 cycles.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,... randomly.
  - Response: same 16-value sequence; out_data/row/col stable while stalled; no element dropped or duplicated.
- Start ignored:
  - Stimulus: pulse start again during STREAM and during DONE.
  - Response: no new ram_en. Returns to IDLE after a single done pulse.
- Reset mid-stream:
  - Stimulus: assert resetn=0 after 5 handshakes, then release and start again.
  - Response: out_valid, busy and done go to 0 immediately. A fresh unload reproduces the full 16-element sequence starting from 62.
- Matmul integration:
  - Stimulus: run matrix_multiplication on the int8 A/B matrices, then start the unloader on done.
  - Response: streamed values equal the expected C matrix row-major.
